// File: rtl/lru_data_feeder_if.sv
// Board-side bus of the LRU data feeder.
//   btn_push   : raw asynchronous push button (board -> feeder)
//   sw_data    : 16-bit switch word enqueued on a press (board -> feeder)
//   data       : word presented to the LRU buffer (feeder -> buffer)
//   valid_data : registered write strobe to the LRU buffer (feeder -> buffer)
//   busy       : FSM not idle or FIFO not empty
//   count      : FIFO occupancy, full : count == DEPTH
//   overflow   : sticky, a press was dropped because the FIFO was full
// The master modport is the feeder; the slave modport is whatever drives
// the buttons/switches and observes the write strobe.
interface lru_data_feeder_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          btn_push;
    logic [15:0]   sw_data;
    logic [15:0]   data;
    logic          valid_data;
    logic          busy;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;

    modport master (
        input  btn_push,
        input  sw_data,
        output data,
        output valid_data,
        output busy,
        output count,
        output full,
        output overflow
    );

    modport slave (
        output btn_push,
        output sw_data,
        input  data,
        input  valid_data,
        input  busy,
        input  count,
        input  full,
        input  overflow
    );
endinterface

// File: rtl/lru_data_feeder.sv
// Producer for the 8-entry LRU buffer write port. A debounced button press
// captures the switch word into a small FIFO; an FSM pops words one at a
// time and frames each as LOAD (data setup, strobe low), HIGH (strobe high
// for PULSE_HIGH cycles) and GAP (strobe low for PULSE_GAP cycles), so the
// buffer always sees a clean rising edge per word.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : lru_data_feeder_if.master (btn_push, sw_data in; data, valid_data,
//         busy, count, full, overflow out)
module lru_data_feeder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_HIGH      = 2,
    parameter int PULSE_GAP       = 2,
    parameter int DEPTH           = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    lru_data_feeder_if.master    bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (PULSE_HIGH > PULSE_GAP) ? PULSE_HIGH : PULSE_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, HIGH, GAP} state_t;

    // Synchronizer and debouncer
    logic           sync1_reg;
    logic           btn_s_reg;
    logic [DBW-1:0] db_cnt_reg;
    logic           stable_reg;
    logic           press_reg;

    // FIFO
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           overflow_reg;
    logic           fifo_full;
    logic           pop;
    logic           push_ok;

    // Framing FSM
    state_t         state_reg, state_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [15:0]    data_reg;
    logic           valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg  <= 1'b0;
            btn_s_reg  <= 1'b0;
            db_cnt_reg <= '0;
            stable_reg <= 1'b0;
            press_reg  <= 1'b0;
        end else begin
            sync1_reg <= bus.btn_push;
            btn_s_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (btn_s_reg != stable_reg) begin
                // The counter holds how many consecutive differing samples
                // preceded this one, so the flip lands on the
                // DEBOUNCE_CYCLES-th differing sample.
                if (db_cnt_reg == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_reg <= btn_s_reg;
                    db_cnt_reg <= '0;
                    press_reg  <= btn_s_reg;   // 0->1 only; release is silent
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end else begin
                db_cnt_reg <= '0;
            end
        end
    end

    assign fifo_full = (count_reg == CW'(DEPTH));
    assign pop       = (state_reg == IDLE) && (count_reg != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = press_reg && (!fifo_full || pop);

    // Storage is left unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= bus.sw_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            data_reg     <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (press_reg && !push_ok) begin
                overflow_reg <= 1'b1;
            end
            if (pop) begin
                // When full, wr_ptr == rd_ptr: the read returns the old head
                // while the new word is written behind it.
                data_reg   <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    state_next = LOAD;
                    timer_next = '0;
                end
            end
            LOAD: begin
                state_next = HIGH;
                timer_next = '0;
            end
            HIGH: begin
                if (timer_reg == TW'(PULSE_HIGH - 1)) begin
                    state_next = GAP;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            GAP: begin
                if (timer_reg == TW'(PULSE_GAP - 1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            // Registered from the next state so the strobe is high exactly
            // while the FSM sits in HIGH, with no combinational glitches.
            valid_reg <= (state_next == HIGH);
        end
    end

    assign bus.data       = data_reg;
    assign bus.valid_data = valid_reg;
    assign bus.busy       = (state_reg != IDLE) || (count_reg != '0);
    assign bus.count      = count_reg;
    assign bus.full       = fifo_full;
    assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_lru_data_feeder.sv
module tb_lru_data_feeder;
    localparam int DEPTH = 4;
    localparam int DEB   = 4;
    localparam int PH_F  = 2;
    localparam int PG_F  = 2;
    localparam int PH_S  = 60;
    localparam int PG_S  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_push;
    logic [15:0] sw_data;

    always #5 clk = ~clk;

    lru_data_feeder_if #(.DEPTH(DEPTH)) if_f ();
    lru_data_feeder_if #(.DEPTH(DEPTH)) if_s ();

    assign if_f.btn_push = btn_push;
    assign if_f.sw_data  = sw_data;
    assign if_s.btn_push = btn_push;
    assign if_s.sw_data  = sw_data;

    lru_data_feeder #(.DEBOUNCE_CYCLES(DEB), .PULSE_HIGH(PH_F), .PULSE_GAP(PG_F), .DEPTH(DEPTH))
        dut_f (.clk(clk), .rst(rst), .bus(if_f.master));
    lru_data_feeder #(.DEBOUNCE_CYCLES(DEB), .PULSE_HIGH(PH_S), .PULSE_GAP(PG_S), .DEPTH(DEPTH))
        dut_s (.clk(clk), .rst(rst), .bus(if_s.master));

    logic        a_valid [2];
    logic [15:0] a_data  [2];
    logic [2:0]  a_count [2];
    logic        a_full  [2];
    logic        a_ovf   [2];
    logic        a_busy  [2];
    assign a_valid[0] = if_f.valid_data;  assign a_valid[1] = if_s.valid_data;
    assign a_data[0]  = if_f.data;        assign a_data[1]  = if_s.data;
    assign a_count[0] = if_f.count;       assign a_count[1] = if_s.count;
    assign a_full[0]  = if_f.full;        assign a_full[1]  = if_s.full;
    assign a_ovf[0]   = if_f.overflow;    assign a_ovf[1]   = if_s.overflow;
    assign a_busy[0]  = if_f.busy;        assign a_busy[1]  = if_s.busy;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Button: the debounced level flips once the last DEB synchronized
    // samples all disagree with it. Each instance: a bounded word queue plus
    // a "cycles since pop" phase counter (0 = idle, 1 = setup, then high
    // for PH cycles, then low for PG cycles).
    logic        dly0, dly1;
    logic        win[$];
    logic        m_stable;
    logic        m_press;
    int          m_since [2];
    logic [15:0] m_data  [2];
    logic        m_ovf   [2];
    logic [15:0] mq      [2][$];
    logic [15:0] acc_log [2][$];
    logic [15:0] rise_log[2][$];
    logic        prev_valid [2];

    function automatic int ph(input int i);
        return (i == 0) ? PH_F : PH_S;
    endfunction

    function automatic int pg(input int i);
        return (i == 0) ? PG_F : PG_S;
    endfunction

    task automatic model_step();
        bit all_diff;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                m_since[i] = 0;
                m_data[i]  = '0;
                m_ovf[i]   = 1'b0;
            end
            m_press  = 1'b0;
            m_stable = 1'b0;
            win.delete();
            dly0 = 1'b0;
            dly1 = 1'b0;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            int  n;
            int  sz;
            bit  do_pop;
            n      = 1 + ph(i) + pg(i);
            sz     = mq[i].size();
            do_pop = (m_since[i] == 0) && (sz > 0);
            if (do_pop) begin
                m_data[i]  = mq[i].pop_front();
                m_since[i] = 1;
            end else if (m_since[i] != 0) begin
                m_since[i] = (m_since[i] == n) ? 0 : m_since[i] + 1;
            end
            if (m_press) begin
                if (sz < DEPTH || do_pop) begin
                    mq[i].push_back(sw_data);
                    acc_log[i].push_back(sw_data);
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
        win.push_back(dly1);
        if (win.size() > DEB) void'(win.pop_front());
        all_diff = (win.size() == DEB);
        foreach (win[j]) if (win[j] == m_stable) all_diff = 1'b0;
        m_press = all_diff && !m_stable;
        if (all_diff) m_stable = !m_stable;
        dly1 = dly0;
        dly0 = btn_push;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic ev;
            logic eb;
            ev = (m_since[i] >= 2) && (m_since[i] <= 1 + ph(i));
            eb = (m_since[i] != 0) || (mq[i].size() != 0);
            check((i == 0) ? "cycle_fast" : "cycle_slow",
                  {9'd0, a_valid[i], a_data[i], a_count[i], a_full[i], a_ovf[i], a_busy[i]},
                  {9'd0, ev, m_data[i], 3'(mq[i].size()), (mq[i].size() == DEPTH), m_ovf[i], eb});
            if (a_valid[i] && !prev_valid[i]) begin
                rise_log[i].push_back(a_data[i]);
                $display("word inst=%0d data=%h t=%0t", i, a_data[i], $time);
            end
            prev_valid[i] = a_valid[i];
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        compare_all();
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            rise_log[i].delete();
            acc_log[i].delete();
        end
    endtask

    task automatic press(input logic [15:0] v, input int hi, input int lo);
        sw_data  = v;
        btn_push = 1'b1;
        repeat (hi) @(negedge clk);
        btn_push = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic drain(input int i);
        int w = 0;
        while ((m_since[i] != 0 || mq[i].size() != 0) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("drain_bound", 32'(w < 3000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Expects the words 1..n in order on instance i.
    task automatic check_run(input string name, input int i, input int n);
        check({name, "_len"}, rise_log[i].size(), n);
        for (int k = 0; k < n && k < rise_log[i].size(); k++)
            check({name, "_word"}, rise_log[i][k], k + 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        btn;
        logic [15:0] sw;
        int          hold;
        bit          chk;
        int          exp_rises;
        int          exp_count;
        logic        exp_ovf;
        logic        exp_busy;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int w;
        for (int i = 0; i < 2; i++) prev_valid[i] = 1'b0;
        rst = 1'b1; btn_push = 1'b0; sw_data = '0;

        tbl[0] = '{1'b1, 16'hA5A5, 10, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 16'hA5A5, 14, 1'b1, 1, 0, 1'b0, 1'b0, 16'hA5A5};
        tbl[2] = '{1'b1, 16'h0BAD,  1, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0000};
        tbl[3] = '{1'b0, 16'h0BAD,  6, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0000};
        tbl[4] = '{1'b1, 16'h0BAD,  2, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0000};
        tbl[5] = '{1'b0, 16'h0BAD,  6, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0000};
        tbl[6] = '{1'b1, 16'h0BAD,  3, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0000};
        tbl[7] = '{1'b0, 16'h0BAD,  8, 1'b1, 1, 0, 1'b0, 1'b0, 16'hA5A5};
        tbl[8] = '{1'b1, 16'h1234,  6, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0000};
        tbl[9] = '{1'b0, 16'h1234, 14, 1'b1, 2, 0, 1'b0, 1'b0, 16'h1234};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++)
            check("reset_state",
                  {9'd0, a_valid[i], a_data[i], a_count[i], a_full[i], a_ovf[i], a_busy[i]}, 32'd0);
        clear_logs();

        // Single clean press, bounces, then one clean press.
        for (int v = 0; v < 10; v++) begin
            btn_push = tbl[v].btn;
            sw_data  = tbl[v].sw;
            repeat (tbl[v].hold) @(negedge clk);
            if (tbl[v].chk) begin
                check("tbl_rises", rise_log[0].size(), tbl[v].exp_rises);
                check("tbl_count", a_count[0], tbl[v].exp_count);
                check("tbl_ovf",   a_ovf[0],   tbl[v].exp_ovf);
                check("tbl_busy",  a_busy[0],  tbl[v].exp_busy);
                check("tbl_data",  a_data[0],  tbl[v].exp_data);
            end
        end

        // Enqueue landing on the same edge as an idle pop while full.
        do_reset();
        clear_logs();
        for (int k = 1; k <= 5; k++) press(16'(k), 5, 5);
        check("coinc_full_before", a_full[1], 1'b1);
        w = 0;
        while (m_since[1] != (1 + PH_S + PG_S) - 6 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("coinc_align_bound", 32'(w < 200), 32'd1);
        @(negedge clk);
        press(16'd6, 5, 5);
        check("coinc_count", a_count[1], 3'd4);
        check("coinc_ovf",   a_ovf[1],   1'b0);
        check("coinc_full",  a_full[1],  1'b1);
        drain(1);
        check_run("coinc_order", 1, 6);

        // Overflow: slow instance saturates, the dropped words never appear.
        clear_logs();
        for (int k = 1; k <= 7; k++) press(16'(k), 5, 5);
        check("ovf_count", a_count[1], 3'd4);
        check("ovf_full",  a_full[1],  1'b1);
        check("ovf_flag",  a_ovf[1],   1'b1);
        check("ovf_fast_flag", a_ovf[0], 1'b0);
        drain(1);
        check_run("ovf_order_slow", 1, 5);
        check_run("ovf_order_fast", 0, 7);
        check("ovf_sticky", a_ovf[1], 1'b1);

        // Reset in the middle of a pulse with two words queued.
        clear_logs();
        for (int k = 1; k <= 3; k++) press(16'(k), 5, 5);
        check("rst_pre_high",  a_valid[1], 1'b1);
        check("rst_pre_count", a_count[1], 3'd2);
        do_reset();
        check("rst_valid", a_valid[1], 1'b0);
        check("rst_count", a_count[1], 3'd0);
        check("rst_ovf",   a_ovf[1],   1'b0);
        check("rst_data",  a_data[1],  16'h0000);
        repeat (150) @(negedge clk);
        check("rst_no_pulse", rise_log[1].size(), 1);

        // Random presses (including short bounces) against the scoreboard.
        do_reset();
        clear_logs();
        for (int p = 0; p < 50; p++)
            press(16'($urandom), $urandom_range(1, 8), $urandom_range(2, 12));
        drain(0);
        drain(1);
        for (int i = 0; i < 2; i++) begin
            check("rand_len", rise_log[i].size(), acc_log[i].size());
            for (int k = 0; k < rise_log[i].size() && k < acc_log[i].size(); k++)
                check("rand_word", rise_log[i][k], acc_log[i][k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
